// File: rtl/unpacker_fsm.sv
// Width converter: holds one wide input word and emits it as narrower chunks with sop/eop/vbc.
// Optional protocol checker and proto_err port enabled by defining UNPACKER_PROTO_CHK_EN.
module unpacker_fsm #(
  parameter int unsigned IN_IFC_SZ_B  = 160,
  parameter int unsigned OUT_IFC_SZ_B = 64
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      val,
  input  logic                      sop,
  input  logic                      eop,
  input  logic [7:0]                vbc,
  input  logic [IN_IFC_SZ_B*8-1:0]  data,
  output logic                      ready,
  input  logic                      out_ready,
  output logic                      out_val,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [7:0]                out_vbc,
  output logic [OUT_IFC_SZ_B*8-1:0] out_data
`ifdef UNPACKER_PROTO_CHK_EN
  ,
  output logic                      proto_err
`endif
);

  localparam logic [7:0] InBytes  = 8'(IN_IFC_SZ_B);
  localparam logic [7:0] OutBytes = 8'(OUT_IFC_SZ_B);

  typedef enum logic [0:0] {StIdle, StUnpack} state_e;

  state_e                   state_q, state_d;
  logic [IN_IFC_SZ_B*8-1:0] data_q, data_d;
  logic                     sop_q, sop_d;
  logic                     eop_q, eop_d;
  logic [7:0]               offset_q, offset_d;
  logic [7:0]               bytes_left_q, bytes_left_d;

  logic       accept;
  logic       last_chunk;
  logic [7:0] eff_vbc;

  // Zero or oversize counts mean a full word.
  assign eff_vbc    = ((vbc == 8'd0) || (vbc > InBytes)) ? InBytes : vbc;
  assign accept     = ready && val;
  assign last_chunk = (bytes_left_q <= OutBytes);

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q      <= StIdle;
      data_q       <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      offset_q     <= 8'd0;
      bytes_left_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      offset_q     <= offset_d;
      bytes_left_q <= bytes_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    offset_d     = offset_q;
    bytes_left_d = bytes_left_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d       = data;
          sop_d        = sop;
          eop_d        = eop;
          offset_d     = 8'd0;
          bytes_left_d = eff_vbc;
          state_d      = StUnpack;
        end
      end
      StUnpack: begin
        if (out_ready) begin
          if (last_chunk) begin
            state_d = StIdle;
          end else begin
            offset_d     = offset_q + OutBytes;
            bytes_left_d = bytes_left_q - OutBytes;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready    = reset_L && (state_q == StIdle);
    out_val  = reset_L && (state_q == StUnpack);
    out_sop  = out_val && sop_q && (offset_q == 8'd0);
    out_eop  = out_val && eop_q && last_chunk;
    out_vbc  = 8'd0;
    out_data = '0;
    if (out_val) begin
      out_vbc = last_chunk ? bytes_left_q : OutBytes;
      // Bytes past bytes_left are forced to zero rather than leaking stale word contents.
      for (int unsigned i = 0; i < OUT_IFC_SZ_B; i++) begin
        if ((i < 32'(bytes_left_q)) && ((32'(offset_q) + i) < IN_IFC_SZ_B)) begin
          out_data[i*8 +: 8] = data_q[(32'(offset_q) + i)*8 +: 8];
        end
      end
    end
  end

`ifdef UNPACKER_PROTO_CHK_EN
  logic in_pkt_q, in_pkt_d;
  logic proto_err_q, proto_err_d;
  logic viol;

  assign viol = (sop && in_pkt_q) || (!sop && !in_pkt_q) || (!eop && (vbc != InBytes)) ||
                (vbc == 8'd0) || (vbc > InBytes);

  always_comb begin
    in_pkt_d    = in_pkt_q;
    proto_err_d = 1'b0;
    if (accept) begin
      proto_err_d = viol;
      if (eop) begin
        in_pkt_d = 1'b0;
      end else if (sop) begin
        in_pkt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      in_pkt_q    <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      in_pkt_q    <= in_pkt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = reset_L && proto_err_q;
`endif

endmodule

// File: tb/tb_unpacker_fsm.sv
// Directed self-checking bench for unpacker_fsm (160B in, 64B out).
module tb_unpacker_fsm;

  logic         clk;
  logic         reset_L;
  logic         val;
  logic         sop;
  logic         eop;
  logic [7:0]   vbc;
  logic [1279:0] data;
  logic         ready;
  logic         out_ready;
  logic         out_val;
  logic         out_sop;
  logic         out_eop;
  logic [7:0]   out_vbc;
  logic [511:0] out_data;
`ifdef UNPACKER_PROTO_CHK_EN
  logic         proto_err;
`endif

  int checks   = 0;
  int failures = 0;

  unpacker_fsm #(
    .IN_IFC_SZ_B (160),
    .OUT_IFC_SZ_B(64)
  ) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .val      (val),
    .sop      (sop),
    .eop      (eop),
    .vbc      (vbc),
    .data     (data),
    .ready    (ready),
    .out_ready(out_ready),
    .out_val  (out_val),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_vbc  (out_vbc),
    .out_data (out_data)
`ifdef UNPACKER_PROTO_CHK_EN
    ,
    .proto_err(proto_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int k, input int seed);
    return 8'(k * 3 + seed);
  endfunction

  task automatic send_word(input logic s, input logic e, input logic [7:0] n, input int seed);
    check("ready_before_send", ready, 1'b1);
    for (int k = 0; k < 160; k++) data[k*8 +: 8] = pat(k, seed);
    sop = s;
    eop = e;
    vbc = n;
    val = 1'b1;
    step();
    val  = 1'b0;
    sop  = 1'b0;
    eop  = 1'b0;
    vbc  = 8'd0;
    data = '0;
  endtask

  task automatic check_chunk(input int off, input int n, input logic es, input logic ee,
                             input int seed);
    logic [511:0] e;
    e = '0;
    for (int i = 0; i < n; i++) e[i*8 +: 8] = pat(off + i, seed);
    check("out_val", out_val, 1'b1);
    check("ready_busy", ready, 1'b0);
    check("out_sop", out_sop, es);
    check("out_eop", out_eop, ee);
    check("out_vbc", out_vbc, 8'(n));
    check("out_data", out_data, e);
  endtask

  task automatic receive_word(input logic s, input logic e, input int eff, input int seed);
    int off;
    int left;
    int n;
    off  = 0;
    left = eff;
    while (left > 0) begin
      n = (left > 64) ? 64 : left;
      check_chunk(off, n, s && (off == 0), e && (left <= 64), seed);
      step();
      off  += 64;
      left -= n;
    end
    check("ready_after_word", ready, 1'b1);
    check("idle_out_val", out_val, 1'b0);
  endtask

  initial begin
    reset_L   = 1'b0;
    val       = 1'b0;
    sop       = 1'b0;
    eop       = 1'b0;
    vbc       = 8'd0;
    data      = '0;
    out_ready = 1'b1;
    #1;
    check("rst_ready", ready, 1'b0);
    check("rst_out_val", out_val, 1'b0);
    step();
    step();
    check("rst_ready_held", ready, 1'b0);
    check("rst_out_val_held", out_val, 1'b0);
    reset_L = 1'b1;
    #1;
    check("post_rst_ready", ready, 1'b1);
    step();

    // 64B single-chunk packet
    send_word(1'b1, 1'b1, 8'd64, 1);
`ifdef UNPACKER_PROTO_CHK_EN
    check("proto_ok_64", proto_err, 1'b0);
`endif
    receive_word(1'b1, 1'b1, 64, 1);

    // 160B packet: 64/64/32
    send_word(1'b1, 1'b1, 8'd160, 7);
    receive_word(1'b1, 1'b1, 160, 7);

    // 161B packet across two words
    send_word(1'b1, 1'b0, 8'd160, 11);
`ifdef UNPACKER_PROTO_CHK_EN
    check("proto_ok_w1", proto_err, 1'b0);
`endif
    receive_word(1'b1, 1'b0, 160, 11);
    send_word(1'b0, 1'b1, 8'd1, 23);
`ifdef UNPACKER_PROTO_CHK_EN
    check("proto_ok_w2", proto_err, 1'b0);
`endif
    receive_word(1'b0, 1'b1, 1, 23);

    // Back-pressure mid-word
    send_word(1'b1, 1'b1, 8'd160, 40);
    check_chunk(0, 64, 1'b1, 1'b0, 40);
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_chunk(64, 64, 1'b0, 1'b0, 40);
      step();
    end
    out_ready = 1'b1;
    check_chunk(64, 64, 1'b0, 1'b0, 40);
    step();
    check_chunk(128, 32, 1'b0, 1'b1, 40);
    step();
    check("stall_ready_after", ready, 1'b1);
    check("stall_out_val_after", out_val, 1'b0);

    // Reset during the second chunk
    send_word(1'b1, 1'b1, 8'd160, 90);
    check_chunk(0, 64, 1'b1, 1'b0, 90);
    step();
    check_chunk(64, 64, 1'b0, 1'b0, 90);
    reset_L = 1'b0;
    step();
    check("midrst_out_val", out_val, 1'b0);
    check("midrst_ready", ready, 1'b0);
    reset_L = 1'b1;
    #1;
    check("midrst_ready_rel", ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("midrst_no_stale", out_val, 1'b0);
    end

    // vbc=0 treated as a full word
    send_word(1'b1, 1'b1, 8'd0, 55);
`ifdef UNPACKER_PROTO_CHK_EN
    check("proto_err_vbc0", proto_err, 1'b1);
`endif
    receive_word(1'b1, 1'b1, 160, 55);
`ifdef UNPACKER_PROTO_CHK_EN
    check("proto_err_pulse_end", proto_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
